// File: rtl/rx_codec_pkg.sv
// Shared types and sizing helpers for the UART-side receive codec blocks.
package rx_codec_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } asm_state_e;

    localparam int DEF_BYTE_W  = 8;
    localparam int DEF_N_BYTES = 36;

    function automatic int word_w(input int byte_w, input int n_bytes);
        return byte_w * n_bytes;
    endfunction

    // Counter must be able to hold the value n_bytes itself.
    function automatic int cnt_w(input int n_bytes);
        return $clog2(n_bytes + 1);
    endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Idle-cycle counter: pulses expire_o on the TIMEOUT_CYC-th consecutive run cycle.
module rx_idle_timer #(
    parameter  int TIMEOUT_CYC = 16,
    localparam int TW          = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic run_i,
    output logic expire_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    assign expire_o = run_i && (cnt_q == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || !run_i || expire_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/rx_word_assembler.sv
// Packs N_BYTES received bytes into one word with a one-deep holding register,
// valid/ready output, optional idle timeout and sticky overflow/frame-error flags.
module rx_word_assembler
    import rx_codec_pkg::*;
#(
    parameter  int BYTE_W      = DEF_BYTE_W,
    parameter  int N_BYTES     = DEF_N_BYTES,
    parameter  int MSB_FIRST   = 1,
    parameter  int TIMEOUT_CYC = 0,
    localparam int WORD_W      = word_w(BYTE_W, N_BYTES),
    localparam int CNT_W       = cnt_w(N_BYTES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_en_i,
    input  logic [BYTE_W-1:0] data_rx_i,
    input  logic              flush_i,
    output logic              wr_valid_o,
    input  logic              wr_ready_i,
    output logic [WORD_W-1:0] wr_data_o,
    output logic [CNT_W-1:0]  byte_cnt_o,
    output logic              overflow_o,
    output logic              frame_err_o
);

    asm_state_e        state_q, state_d;
    logic [WORD_W-1:0] asm_q, asm_d, hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, lane;
    logic              valid_q, valid_d, ovf_q, ovf_d, ferr_q, ferr_d;
    logic              accept, last, hs, expire;

    // A byte arriving together with flush is dropped.
    assign accept = rx_en_i && !flush_i;
    assign last   = accept && (cnt_q == CNT_W'(N_BYTES - 1));
    assign hs     = valid_q && wr_ready_i;
    assign lane   = (MSB_FIRST != 0) ? CNT_W'(N_BYTES - 1) - cnt_q : cnt_q;

    if (TIMEOUT_CYC > 0) begin : g_timer
        rx_idle_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .clr_i    (flush_i),
            .run_i    ((state_q == COLLECT) && !rx_en_i),
            .expire_o (expire)
        );
    end else begin : g_no_timer
        assign expire = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        ferr_d  = ferr_q;

        for (int b = 0; b < N_BYTES; b++) begin
            if (accept && lane == CNT_W'(b)) asm_d[b*BYTE_W +: BYTE_W] = data_rx_i;
        end

        if (hs) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = COLLECT;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            COLLECT: begin
                if (flush_i || expire) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    // Hold frees up this cycle if it is empty or being handed off.
                    if (!valid_q || hs) begin
                        hold_d  = asm_d;
                        valid_d = 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            ovf_d  = 1'b0;
            ferr_d = 1'b0;
        end
        if (expire) ferr_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            asm_q   <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
        end
    end

    assign wr_valid_o  = valid_q;
    assign wr_data_o   = hold_q;
    assign byte_cnt_o  = cnt_q;
    assign overflow_o  = ovf_q;
    assign frame_err_o = ferr_q;

endmodule
